// File: rtl/sync_filt_multi.sv
// sync_filt_multi: per-channel multi-flop synchroniser, stability filter and registered edge pulses.
// Defining SYNC_FILT_STICKY_EN adds sticky pending flags that are cleared by clr_i.
module sync_filt_multi #(
    parameter int               WIDTH      = 1,
    parameter int               STAGES     = 2,
    parameter int               FILTER_LEN = 1,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] serial_i,
    input  logic [WIDTH-1:0] clr_i,
    output logic [WIDTH-1:0] serial_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] pend_rise_o,
    output logic [WIDTH-1:0] pend_fall_o
);
    localparam int            CW   = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

    if (WIDTH < 1 || STAGES < 2 || FILTER_LEN < 1) begin : g_bad_params
        $error("sync_filt_multi: need WIDTH>=1, STAGES>=2, FILTER_LEN>=1");
    end

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [CW-1:0]    cnt_d  [WIDTH];
    logic [WIDTH-1:0] out_q, out_d, rise_q, rise_d, fall_q, fall_d;
    logic [WIDTH-1:0] synced, diff, take;

    assign synced = sync_q[STAGES-1];
    assign diff   = synced ^ out_q;

    // A channel accepts its synced level once it has disagreed for FILTER_LEN consecutive cycles.
    always_comb begin
        take = '0;
        for (int i = 0; i < WIDTH; i++) begin
            take[i]  = diff[i] && (cnt_q[i] == LAST);
            cnt_d[i] = (diff[i] && !take[i]) ? cnt_q[i] + CW'(1) : '0;
        end
        out_d  = out_q ^ take;
        rise_d = take & synced;
        fall_d = take & ~synced;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < STAGES; k++) sync_q[k] <= RESET_VAL;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            out_q  <= RESET_VAL;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            sync_q[0] <= serial_i;
            for (int k = 1; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign serial_o = out_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

`ifdef SYNC_FILT_STICKY_EN
    logic [WIDTH-1:0] pend_rise_q, pend_fall_q;

    // A pulse arriving with clr_i keeps its flag set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_rise_q <= '0;
            pend_fall_q <= '0;
        end else begin
            pend_rise_q <= rise_q | (pend_rise_q & ~clr_i);
            pend_fall_q <= fall_q | (pend_fall_q & ~clr_i);
        end
    end

    assign pend_rise_o = pend_rise_q;
    assign pend_fall_o = pend_fall_q;
`else
    logic unused_clr;
    assign unused_clr  = ^clr_i;
    assign pend_rise_o = '0;
    assign pend_fall_o = '0;
`endif
endmodule

// File: tb/tb_sync_filt_multi.sv
// tb_sync_filt_multi: directed and random checks of sync_filt_multi against a history-window model.
module tb_sync_filt_multi;
    localparam int               W  = 4;
    localparam int               S  = 3;
    localparam int               F  = 4;
    localparam logic [W-1:0]     RV = 4'b1010;
`ifdef SYNC_FILT_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] ser, clr, so, ro, fo, pr, pf;
    logic [0:0]   s1, c1, so1, ro1, fo1, pr1, pf1;

    sync_filt_multi #(.WIDTH(W), .STAGES(S), .FILTER_LEN(F), .RESET_VAL(RV)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .serial_i(ser), .clr_i(clr),
        .serial_o(so), .rise_o(ro), .fall_o(fo), .pend_rise_o(pr), .pend_fall_o(pf)
    );

    sync_filt_multi #(.WIDTH(1), .STAGES(2), .FILTER_LEN(1), .RESET_VAL(1'b0)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .serial_i(s1), .clr_i(c1),
        .serial_o(so1), .rise_o(ro1), .fall_o(fo1), .pend_rise_o(pr1), .pend_fall_o(pf1)
    );

    // Model: the filter sees the input sampled S edges earlier; the output flips when the
    // last F seen values all disagree with it and at least F edges have passed since the last flip.
    logic [W-1:0] hist[$];
    logic [W-1:0] shist[$];
    logic [W-1:0] mout, mrise, mfall, mpr, mpf;
    int           last_chg[W];
    int           n;
    int           total = 0;
    int           fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        shist.delete();
        for (int k = 0; k < S; k++) hist.push_back(RV);
        mout = RV; mrise = '0; mfall = '0; mpr = '0; mpf = '0; n = 0;
        for (int c = 0; c < W; c++) last_chg[c] = 0;
    endtask

    task automatic edge_step();
        logic stable;
        @(posedge clk);
        n++;
        hist.push_back(ser);
        shist.push_back(hist[hist.size()-1-S]);
        mpr = mrise | (mpr & ~clr);
        mpf = mfall | (mpf & ~clr);
        mrise = '0;
        mfall = '0;
        for (int c = 0; c < W; c++) begin
            if (n - last_chg[c] >= F) begin
                stable = 1'b1;
                for (int k = 0; k < F; k++)
                    if (shist[shist.size()-1-k][c] == mout[c]) stable = 1'b0;
                if (stable) begin
                    mout[c] = ~mout[c];
                    if (mout[c]) mrise[c] = 1'b1; else mfall[c] = 1'b1;
                    last_chg[c] = n;
                end
            end
        end
        #1;
        chk("serial_o", 32'(so), 32'(mout));
        chk("rise_o", 32'(ro), 32'(mrise));
        chk("fall_o", 32'(fo), 32'(mfall));
        chk("pend_rise_o", 32'(pr), STICKY ? 32'(mpr) : 32'd0);
        chk("pend_fall_o", 32'(pf), STICKY ? 32'(mpf) : 32'd0);
        chk("rise_and_fall", 32'(ro & fo), 32'd0);
    endtask

    task automatic rand_cycles(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            for (int c = 0; c < W; c++)
                if ($urandom_range(0, 4) == 0) ser[c] = ~ser[c];
            for (int c = 0; c < W; c++) clr[c] = ($urandom_range(0, 3) == 0);
            s1  = 1'($urandom_range(0, 1));
            c1  = 1'($urandom_range(0, 1));
            edge_step();
        end
    endtask

    initial begin
        ser = RV; clr = '0; s1 = 1'b0; c1 = 1'b0;
        #12;
        chk("reset serial_o", 32'(so), 32'(RV));
        chk("reset pulses", 32'({ro, fo}), 32'd0);
        chk("reset pend", 32'({pr, pf}), 32'd0);
        chk("reset dut1 serial_o", 32'(so1), 32'd0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;

        // Directed: ch0 gets a 3-cycle then a 4-cycle pulse; ch3..1 invert and hold.
        for (int i = 1; i <= 18; i++) begin
            ser[0]   = (i <= 3) || (i >= 6 && i <= 9);
            ser[3:1] = ~RV[3:1];
            s1       = (i <= 4);
            edge_step();
            if (i <= 2) chk("dut1 latency hold", 32'(so1), 32'd0);
            if (i == 3) chk("dut1 rise edge3", 32'({so1, ro1}), 32'b11);
            if (i == 4) chk("dut1 rise one cycle", 32'({so1, ro1}), 32'b10);
            if (i == 7) chk("dut1 fall edge7", 32'({so1, fo1}), 32'b01);
            if (i == 7) chk("multi ch edge7", 32'({so, ro, fo}), 32'({4'b0100, 4'b0100, 4'b1010}));
            if (i == 12) chk("ch0 accepted 4-cycle pulse", 32'({so[0], ro[0]}), 32'b11);
            if (i == 16) chk("ch0 fall after pulse", 32'({so[0], fo[0]}), 32'b01);
        end

        rand_cycles(300);

        // Reset mid-filter: settle, invert inputs, then assert reset asynchronously.
        for (int i = 0; i < 10; i++) begin
            clr = '0;
            edge_step();
        end
        ser = ~ser;
        for (int i = 0; i < 5; i++) edge_step();
        #2 rst_n = 1'b0;
        #1;
        chk("async reset serial_o", 32'(so), 32'(RV));
        chk("async reset pulses", 32'({ro, fo, pr, pf}), 32'd0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 12; i++) edge_step();

        rand_cycles(300);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/sync_filt_multi.md
Name: sync_filt_multi

Overview:
- Multi-channel successor to the single-bit synchroniser.
- Takes WIDTH asynchronous inputs through a configurable-depth flop chain, then a per-channel stability (glitch) filter.
- Emits the filtered level plus registered one-cycle rise/fall pulses per channel.
- Sits at the chip/subsystem boundary for GPIO, interrupt lines and external handshake signals.

Parameters:
- WIDTH, 1: number of independent channels.
- STAGES, 2: synchroniser flops per channel; must be >= 2.
- FILTER_LEN, 1: consecutive stable synced cycles required before the filtered level changes; must be >= 1.
- RESET_VAL, '0 (WIDTH bits): per-channel reset level for the sync chain and filtered output.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- serial_i  input  WIDTH  asynchronous inputs, one per channel.
- clr_i  input  WIDTH  per-channel clear for sticky pending flags; ignored when the sticky feature is compiled out.
- serial_o  output  WIDTH  filtered, synchronised level.
- rise_o  output  WIDTH  one-cycle pulse on a filtered 0->1 change.
- fall_o  output  WIDTH  one-cycle pulse on a filtered 1->0 change.
- pend_rise_o  output  WIDTH  sticky rise flag; tied 0 without the feature.
- pend_fall_o  output  WIDTH  sticky fall flag; tied 0 without the feature.

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - All sync flops and serial_o = RESET_VAL.
  - Filter counters = 0.
  - rise_o, fall_o, pend_* = 0.
- Sync chain: per channel, shift register of STAGES flops.
  - synced[i] = last stage, so it reflects serial_i STAGES edges after capture.
- Filter, per channel, counter cnt of width $clog2(FILTER_LEN+1):
  - synced == serial_o: cnt <= 0.
  - synced != serial_o and cnt < FILTER_LEN-1: cnt <= cnt+1.
  - synced != serial_o and cnt == FILTER_LEN-1: serial_o <= synced; cnt <= 0.
  - Total latency for a stable input change: serial_o updates on edge STAGES+FILTER_LEN after the first capturing edge.
  - FILTER_LEN=1 gives latency STAGES+1 with no rejection.
- Glitch rejection: any synced deviation lasting fewer than FILTER_LEN cycles resets cnt; serial_o and the pulses are unaffected.
- Pulses: rise_o/fall_o are registered and asserted exactly in the cycle serial_o shows its new value, for one cycle only.
  - rise_o and fall_o are never both high on a channel.
- Back-to-back changes: each accepted change yields its own pulse. Minimum spacing between pulses on one channel is FILTER_LEN cycles.
- Channels are fully independent: no shared counters, no cross-channel ordering guarantee.
- Reset release: if serial_i differs from RESET_VAL, a normal filtered change and its pulse follow after STAGES+FILTER_LEN cycles. This is intended behaviour.
- Reset mid-filter: the partial count is discarded and no pulse is emitted.
- Elaboration error if STAGES<2, FILTER_LEN<1 or WIDTH<1.

Optional Feature:
Macro: SYNC_FILT_STICKY_EN
- Defined:
  - pend_rise_o[i] sets on rise_o[i]; pend_fall_o[i] sets on fall_o[i].
  - Both flags hold until clr_i[i]=1 on a clock edge.
  - Set and clear in the same cycle: the set wins, so the flag stays 1.
  - clr_i clears both flags of channel i.
  - Flags are registered: a flag goes high one cycle after its pulse.
- Not defined:
  - pend_rise_o = pend_fall_o = 0 constantly.
  - clr_i is unused; no flops are inferred for the flags.

Test Plan:
- Latency, WIDTH=1, STAGES=2, FILTER_LEN=1, RESET_VAL=0: after reset, drive serial_i 0->1 before edge 1 -> serial_o=1 and rise_o=1 at edge 3. rise_o=0 at edge 4.
- Glitch rejection, WIDTH=1, STAGES=3, FILTER_LEN=4: a 3-cycle high pulse on serial_i -> serial_o stays 0 and no rise_o. A 4-cycle pulse -> serial_o=1 at edge 7 with rise_o, then fall_o 4 cycles after the synced level returns low.
- Multi-channel independence, WIDTH=4, STAGES=2, FILTER_LEN=2, RESET_VAL=4'b1010: after reset serial_o=4'b1010. Drive serial_i=4'b0101 -> at edge 4 serial_o=4'b0101, rise_o=4'b0101, fall_o=4'b1010.
- Reset mid-filter, FILTER_LEN=8: change the input, assert rst_ni low after 5 cycles -> serial_o returns to RESET_VAL immediately (asynchronous), no pulse. Re-filtering starts after release.
- Sticky with SYNC_FILT_STICKY_EN defined: rise on ch0 -> pend_rise_o[0]=1 the next cycle. clr_i[0] coincident with a new rise_o[0] -> flag stays 1. A later lone clr_i[0] -> flag 0.
- Sticky compiled out: the same stimulus -> pend_* remain 0 throughout; rise_o/fall_o identical to the defined build.
